fetch_redirect_ctrl: RTL and testbench

- Sequences the fetch-stage PC source selection.
- Owns the PC register and drives the instruction-memory request handshake.
- Arbitrates among three PC sources: sequential PC+4, taken branch resolved in EX, and jump decoded in ID.
- Generates registered pipeline flushes, drops the stale response of an in-flight fetch, traps misaligned redirect targets and counts accepted redirects for performance monitoring.

---
 rtl/fetch_redirect_ctrl_if.sv | 37 +++
 rtl/fetch_redirect_ctrl.sv | 96 +++++++++
 tb/tb_fetch_redirect_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch redirect controller bus: hazard/redirect inputs, imem handshake and
// flush/fault/perf outputs. The master side is the controller. The slave side
// is the surrounding pipeline, or a bench driving it.
//   stall, imem_ready, branch_*, jump*       : pipeline -> controller
//   pc, fetch_req, drop_resp, flush_*, fault : controller -> pipeline
//   branch_cnt, jump_cnt                     : saturating redirect counters
interface fetch_redirect_ctrl_if #(
  parameter int Width = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             imem_ready;
  logic             branch_taken;
  logic [Width-1:0] branch_target;
  logic             jump;
  logic [Width-1:0] jump_target;
  logic [Width-1:0] pc;
  logic             fetch_req;
  logic             drop_resp;
  logic             flush_if;
  logic             flush_id;
  logic             fault;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] jump_cnt;

  modport master (
    input  stall, imem_ready, branch_taken, branch_target, jump, jump_target,
    output pc, fetch_req, drop_resp, flush_if, flush_id, fault,
           branch_cnt, jump_cnt
  );

  modport slave (
    output stall, imem_ready, branch_taken, branch_target, jump, jump_target,
    input  pc, fetch_req, drop_resp, flush_if, flush_id, fault,
           branch_cnt, jump_cnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC sequencer. It owns the PC and the imem request handshake.
// It picks the next PC from three sources, in priority order: EX branch,
// ID jump, then sequential PC+4.
// A redirect that arrives while a request is outstanding is parked in
// REDIR_WAIT until that request completes. While parked, drop_resp marks the
// stale word for discard. A misaligned target traps into a sticky FAULT state.
// Ports: clk, reset (sync, active high), bus (master modport of
// fetch_redirect_ctrl_if).
module fetch_redirect_ctrl #(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input logic                 clk,
  input logic                 reset,
  fetch_redirect_ctrl_if.master bus
);
  typedef enum logic [1:0] {BOOT, FETCH, REDIR_WAIT, FAULT} state_t;

  state_t           state;
  logic [Width-1:0] pending;
  logic [Width-1:0] tgt;
  logic             redir;
  logic             accept;

  // Request lines decode straight from state. In FETCH, stall gates the
  // request. In REDIR_WAIT, the outstanding request must be held until it
  // completes, so stall has no effect there.
  always_comb begin
    bus.fetch_req = 1'b0;
    bus.drop_resp = 1'b0;
    case (state)
      FETCH:      bus.fetch_req = ~bus.stall;
      REDIR_WAIT: begin
        bus.fetch_req = 1'b1;
        bus.drop_resp = 1'b1;
      end
      default: ;
    endcase
  end

  assign redir  = (state == FETCH) && (bus.branch_taken || bus.jump);
  assign tgt    = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign accept = bus.fetch_req && bus.imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      bus.pc         <= RESET_PC;
      pending        <= '0;
      bus.flush_if   <= 1'b0;
      bus.flush_id   <= 1'b0;
      bus.fault      <= 1'b0;
      bus.branch_cnt <= '0;
      bus.jump_cnt   <= '0;
    end else begin
      bus.flush_if <= 1'b0;
      bus.flush_id <= 1'b0;
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (redir) begin
            if (tgt[1:0] != 2'b00) begin
              bus.fault <= 1'b1;
              state     <= FAULT;
            end else begin
              bus.flush_if <= 1'b1;
              bus.flush_id <= bus.branch_taken;
              // A jump that coincides with a branch loses and is not counted.
              if (bus.branch_taken) begin
                if (bus.branch_cnt != '1) bus.branch_cnt <= bus.branch_cnt + 1'b1;
              end else begin
                if (bus.jump_cnt != '1) bus.jump_cnt <= bus.jump_cnt + 1'b1;
              end
              if (bus.fetch_req && !bus.imem_ready) begin
                pending <= tgt;
                state   <= REDIR_WAIT;
              end else begin
                bus.pc <= tgt;
              end
            end
          end else if (accept) begin
            bus.pc <= bus.pc + Width'(4);
          end
        end
        REDIR_WAIT: begin
          if (bus.imem_ready) begin
            bus.pc <= pending;
            state  <= FETCH;
          end
        end
        default: ; // FAULT: frozen until reset
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;
  localparam int W = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_redirect_ctrl_if #(.Width(W), .CNT_W(CW)) bus ();

  fetch_redirect_ctrl #(.Width(W), .RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model. It tracks what the fetch unit is doing:
  // booting, normal fetch, waiting out a stale request, or trapped.
  bit           m_boot, m_wait, m_trap;
  logic [W-1:0] m_pc, m_pend;
  bit           m_fi, m_fd;
  int           m_bc, m_jc;

  function automatic bit m_req();
    if (m_boot || m_trap) return 1'b0;
    if (m_wait) return 1'b1;
    return !bus.stall;
  endfunction

  function automatic bit m_drop();
    return m_wait && !m_boot && !m_trap;
  endfunction

  // Advance the model with the current inputs, then the clock.
  task automatic tick();
    longint t;
    if (reset) begin
      m_boot = 1; m_wait = 0; m_trap = 0; m_pc = 0; m_pend = 0;
      m_fi = 0; m_fd = 0; m_bc = 0; m_jc = 0;
    end else begin
      m_fi = 0; m_fd = 0;
      if (m_boot) m_boot = 0;
      else if (m_trap) ;
      else if (m_wait) begin
        if (bus.imem_ready) begin m_pc = m_pend; m_wait = 0; end
      end else if (bus.branch_taken || bus.jump) begin
        t = bus.branch_taken ? bus.branch_target : bus.jump_target;
        if (t % 4 != 0) m_trap = 1;
        else begin
          m_fi = 1; m_fd = bus.branch_taken;
          if (bus.branch_taken) m_bc = (m_bc + 1 > 15) ? 15 : m_bc + 1;
          else m_jc = (m_jc + 1 > 15) ? 15 : m_jc + 1;
          if (!bus.stall && !bus.imem_ready) begin m_pend = t[W-1:0]; m_wait = 1; end
          else m_pc = t[W-1:0];
        end
      end else if (!bus.stall && bus.imem_ready) begin
        m_pc = W'((longint'(m_pc) + 4) % (longint'(1) << W));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.imem_ready = 1; bus.branch_taken = 0; bus.jump = 0;
    bus.branch_target = 0; bus.jump_target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); end
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL boot_req got %b exp 0", bus.fetch_req); end
    n_checks++; if (bus.drop_resp !== 1'b0) begin n_fail++; $display("FAIL boot_drop got %b exp 0", bus.drop_resp); end
    n_checks++; if ({bus.fault, bus.flush_if, bus.flush_id} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {bus.fault, bus.flush_if, bus.flush_id}); end
    n_checks++; if ({bus.branch_cnt, bus.jump_cnt} !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got %h exp 00", {bus.branch_cnt, bus.jump_cnt}); end
    tick();
  endtask

  task automatic test_sequential();
    logic [W-1:0] e;
    do_reset(); tick(); // leave BOOT
    for (int i = 0; i < 5; i++) begin
      e = W'(4 * i);
      #1;
      n_checks++; if (bus.pc !== e || bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL seq_pc[%0d] got %h/%b exp %h/1", i, bus.pc, bus.fetch_req, e); end
      tick();
    end
    bus.branch_taken = 1; bus.branch_target = 32'hFFFF_FFFC; tick();
    bus.branch_taken = 0; #1;
    n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre got %h exp fffffffc", bus.pc); end
    tick(); #1;
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap got %h exp 0", bus.pc); end
  endtask

  task automatic test_priority();
    do_reset(); tick();
    bus.branch_taken = 1; bus.branch_target = 32'h100;
    bus.jump = 1; bus.jump_target = 32'h200;
    tick(); idle_inputs(); #1;
    n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL prio_pc got %h exp 100", bus.pc); end
    n_checks++; if ({bus.flush_if, bus.flush_id} !== 2'b11) begin n_fail++; $display("FAIL prio_flush got %b exp 11", {bus.flush_if, bus.flush_id}); end
    n_checks++; if (bus.branch_cnt !== 4'd1 || bus.jump_cnt !== 4'd0) begin n_fail++; $display("FAIL prio_cnt got %0d/%0d exp 1/0", bus.branch_cnt, bus.jump_cnt); end
    tick(); #1;
    n_checks++; if ({bus.flush_if, bus.flush_id} !== 2'b00) begin n_fail++; $display("FAIL flush_pulse got %b exp 00", {bus.flush_if, bus.flush_id}); end
  endtask

  task automatic test_redir_wait();
    do_reset(); tick();
    bus.imem_ready = 0; bus.jump = 1; bus.jump_target = 32'h40;
    tick();
    // Redirect requests during the wait must be ignored, and stall must not drop the request.
    bus.jump = 0; bus.branch_taken = 1; bus.branch_target = 32'h300; bus.stall = 1; #1;
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wait_pc got %h exp 0", bus.pc); end
    n_checks++; if (bus.drop_resp !== 1'b1 || bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL wait_req got %b/%b exp 1/1", bus.drop_resp, bus.fetch_req); end
    n_checks++; if ({bus.flush_if, bus.flush_id} !== 2'b10) begin n_fail++; $display("FAIL wait_flush got %b exp 10", {bus.flush_if, bus.flush_id}); end
    tick(); tick(); tick();
    bus.imem_ready = 1; tick();
    idle_inputs(); #1;
    n_checks++; if (bus.pc !== 32'h40 || bus.drop_resp !== 1'b0) begin n_fail++; $display("FAIL wait_done got %h/%b exp 40/0", bus.pc, bus.drop_resp); end
    n_checks++; if (bus.jump_cnt !== 4'd1 || bus.branch_cnt !== 4'd0) begin n_fail++; $display("FAIL wait_cnt got %0d/%0d exp 0/1", bus.branch_cnt, bus.jump_cnt); end
  endtask

  task automatic test_stall();
    logic [W-1:0] p;
    do_reset(); tick(); tick();
    bus.stall = 1; #1;
    p = bus.pc;
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b exp 0", bus.fetch_req); end
    tick(); #1;
    n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL stall_hold got %h exp 4 (was %h)", bus.pc, p); end
    bus.branch_taken = 1; bus.branch_target = 32'h80; tick();
    idle_inputs(); #1;
    n_checks++; if (bus.pc !== 32'h80 || bus.flush_id !== 1'b1) begin n_fail++; $display("FAIL stall_redir got %h/%b exp 80/1", bus.pc, bus.flush_id); end
  endtask

  task automatic test_fault();
    do_reset(); tick(); tick(); // pc = 4
    bus.jump = 1; bus.jump_target = 32'h42; tick();
    bus.jump = 0; bus.branch_taken = 1; bus.branch_target = 32'h100; #1;
    n_checks++; if (bus.fault !== 1'b1 || bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL trap got %b/%b exp 1/0", bus.fault, bus.fetch_req); end
    n_checks++; if (bus.pc !== 32'h4 || bus.flush_if !== 1'b0 || bus.jump_cnt !== 4'd0) begin n_fail++; $display("FAIL trap_state got %h/%b/%0d exp 4/0/0", bus.pc, bus.flush_if, bus.jump_cnt); end
    tick(); tick(); #1;
    n_checks++; if (bus.pc !== 32'h4 || bus.fault !== 1'b1) begin n_fail++; $display("FAIL trap_frozen got %h/%b exp 4/1", bus.pc, bus.fault); end
    reset = 1; tick(); reset = 0; idle_inputs(); #1;
    n_checks++; if (bus.pc !== 32'h0 || bus.fault !== 1'b0 || bus.fetch_req !== 1'b0 || bus.branch_cnt !== 4'd0) begin n_fail++; $display("FAIL trap_reset got %h/%b/%b/%0d exp 0/0/0/0", bus.pc, bus.fault, bus.fetch_req, bus.branch_cnt); end
  endtask

  task automatic test_saturation();
    do_reset(); tick();
    for (int i = 0; i < 17; i++) begin
      bus.branch_taken = 1; bus.branch_target = W'(16 * i); tick();
      #1;
      n_checks++; if ({bus.flush_if, bus.flush_id} !== 2'b11) begin n_fail++; $display("FAIL b2b_flush[%0d] got %b exp 11", i, {bus.flush_if, bus.flush_id}); end
    end
    idle_inputs(); #1;
    n_checks++; if (bus.branch_cnt !== 4'hF) begin n_fail++; $display("FAIL sat got %h exp f", bus.branch_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset             = ($urandom_range(0, 99) == 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.imem_ready    = ($urandom_range(0, 2) != 0);
      bus.branch_taken  = ($urandom_range(0, 5) == 0);
      bus.jump          = ($urandom_range(0, 5) == 0);
      bus.branch_target = {$urandom, 2'b00} >> 2 << 2 | (($urandom_range(0, 31) == 0) ? 32'h2 : 32'h0);
      bus.jump_target   = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 31) == 0) ? 32'h1 : 32'h0);
      #1;
      n_checks++;
      if (bus.pc !== m_pc || bus.fetch_req !== m_req() || bus.drop_resp !== m_drop() ||
          bus.flush_if !== m_fi || bus.flush_id !== m_fd || bus.fault !== m_trap ||
          bus.branch_cnt !== CW'(m_bc) || bus.jump_cnt !== CW'(m_jc)) begin
        n_fail++;
        $display("FAIL rand[%0d] got pc=%h req=%b drop=%b fi=%b fd=%b flt=%b bc=%0d jc=%0d exp pc=%h req=%b drop=%b fi=%b fd=%b flt=%b bc=%0d jc=%0d",
                 i, bus.pc, bus.fetch_req, bus.drop_resp, bus.flush_if, bus.flush_id, bus.fault,
                 bus.branch_cnt, bus.jump_cnt, m_pc, m_req(), m_drop(), m_fi, m_fd, m_trap, m_bc, m_jc);
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_priority();
    test_redir_wait();
    test_stall();
    test_fault();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
